pix_unpack: RTL and testbench
=============================

# pix_unpack

Byte-to-pixel assembler between the UART receiver and the frame RAM. It takes 8-bit bytes from the UART receiver while the system is in image-receive mode (state 2). It packs each byte pair into one RGB444 pixel, counts pixels up to a full frame, and returns a per-block XOR check code to the UART transmit path. It drives the RAM write port (pixel, valid, count) and the receiving flag that arbitrates the transmit mux.

## Interface
Parameters:
- PIX_TOTAL, 19200: pixels per frame (160x120); max 32767.
- BLOCK_PIX, 64: pixels per check-code block; must divide PIX_TOTAL.
- TIMEOUT_CYC, 500000: idle clocks (10 ms at 50 MHz) before an unfinished pixel pair is discarded.

Ports:
- i_clk_sys  in  1  system clock, 50 MHz; the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_rx_data  in  8  received byte; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe, one per byte.
- i_state  in  8  system state; 2 = image receive.
- o_pix  out  12  assembled pixel {R,G,B}.
- o_pix_valid  out  1  one-cycle strobe per pixel.
- o_pix_cnt  out  15  pixels accepted in the current frame.
- o_receiving  out  1  high while a frame is in progress.
- o_check_code  out  8  XOR of all bytes in the last completed block.
- o_check_valid  out  1  one-cycle strobe per completed block.
- o_frame_done  out  1  one-cycle strobe when pixel PIX_TOTAL is written.

## Operation
- Byte format:
  - First byte = {R[3:0], G[3:0]}.
  - Second byte = {B[3:0], 4'b0000}; its low nibble is ignored but still enters the XOR.
  - o_pix = {byte0, byte1[7:4]}.
- FSM states: IDLE, HI (waiting for first byte), LO (waiting for second byte), DONE.
  - IDLE -> HI when i_state==2. On entry: o_pix_cnt=0, XOR accumulator=0, o_receiving=1.
  - HI -> LO on i_rx_done. Latch the byte and XOR it into the accumulator.
  - LO -> HI on i_rx_done. Emit the pixel, increment o_pix_cnt, XOR the byte into the accumulator.
  - After a pixel where o_pix_cnt becomes a multiple of BLOCK_PIX:
    - o_check_code = accumulator value including the current byte.
    - o_check_valid pulses; accumulator clears.
  - After a pixel where o_pix_cnt reaches PIX_TOTAL: go to DONE, pulse o_frame_done, drop o_receiving.
  - DONE -> IDLE when i_state!=2. Bytes arriving in DONE are ignored.
  - From HI or LO, i_state!=2 aborts to IDLE. o_pix_cnt holds its value, o_receiving=0, and no check or frame pulse is produced.
- Bytes in IDLE are ignored.
- i_rx_done arriving in the same cycle as i_state leaving 2: the abort takes priority and the byte is dropped.

## Timing
- Reset values: all outputs 0, FSM in IDLE, accumulator 0.
- o_pix, o_pix_valid, o_pix_cnt (new value), o_check_code and o_check_valid all update 1 clock after the i_rx_done of the second byte. The check strobe coincides with o_pix_valid.
- o_frame_done pulses in the same cycle as the final o_pix_valid. o_receiving is low from the following cycle.
- o_pix and o_check_code hold their values between strobes.
- o_receiving rises 1 clock after i_state becomes 2.
- Reset asserted mid-frame: all state is cleared on the next clock edge. If i_state is still 2 after reset, a new frame starts.

## Configuration
- PIX_UNPACK_TIMEOUT_EN defined:
  - A counter runs while in LO and is cleared by any i_rx_done.
  - When it reaches TIMEOUT_CYC: discard the latched first byte, remove it from the accumulator (XOR it out), and return to HI.
  - o_pix_cnt is unchanged and nothing is strobed.
- Not defined: no counter; LO waits indefinitely.

## Test plan
- Reset, then i_state=2, bytes 0x12, 0x30 -> o_pix=0x123, o_pix_valid for 1 clock, 1 clock after the second strobe; o_pix_cnt=1.
- BLOCK_PIX=2, bytes 0x12,0x30,0x45,0x60 -> o_check_valid pulses with o_check_code=0x12^0x30^0x45^0x60=0x07, coincident with the second o_pix_valid.
- PIX_TOTAL=4, BLOCK_PIX=2, 8 bytes -> o_frame_done pulses with the 4th pixel; o_receiving=0 next clock; a 9th byte produces no strobe.
- Mid-frame (pix_cnt=1, HI latched 0xAB) set i_state=1 -> no further pixel strobes, o_receiving=0. Set i_state=2 again -> o_pix_cnt restarts at 0.
- PIX_UNPACK_TIMEOUT_EN, TIMEOUT_CYC=100: byte 0x12, wait 100 clocks, then bytes 0x34, 0x50 -> o_pix=0x345.
  - Without the macro, the same stimulus gives o_pix=0x123 on the 0x34 byte.
- i_rst pulse during LO -> all outputs 0 next clock; the next frame assembles correctly from its first byte.

Source files
------------

// File: rtl/pix_unpack_if.sv
// Byte-in / pixel-out bundle between the UART receiver, frame RAM and transmit mux.
// Latency: none (wires only).
// Backpressure: none; the receiver strobes bytes and the RAM write side must keep up.
interface pix_unpack_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic [7:0]  i_state;
    logic [11:0] o_pix;
    logic        o_pix_valid;
    logic [14:0] o_pix_cnt;
    logic        o_receiving;
    logic [7:0]  o_check_code;
    logic        o_check_valid;
    logic        o_frame_done;

    // Side that feeds bytes and system state, and consumes pixels/check codes.
    modport master (
        output i_rx_data, i_rx_done, i_state,
        input  o_pix, o_pix_valid, o_pix_cnt, o_receiving,
        input  o_check_code, o_check_valid, o_frame_done
    );

    // The unpacker itself.
    modport slave (
        input  i_rx_data, i_rx_done, i_state,
        output o_pix, o_pix_valid, o_pix_cnt, o_receiving,
        output o_check_code, o_check_valid, o_frame_done
    );
endinterface

// File: rtl/pix_unpack.sv
// Packs UART byte pairs into RGB444 pixels, counts a frame, emits per-block XOR check codes.
// Latency: pixel, count and check strobe appear 1 clock after the second byte's i_rx_done.
// Backpressure: none; bytes are consumed on their strobe. Define PIX_UNPACK_TIMEOUT_EN to drop stale half-pixels.
module pix_unpack #(
    parameter int PIX_TOTAL   = 19200,
    parameter int BLOCK_PIX   = 64,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic        i_clk_sys,
    input  logic        i_rst,
    pix_unpack_if.slave bus
);

    localparam logic [7:0] RX_STATE = 8'd2;
    localparam int         BLK_W    = (BLOCK_PIX > 1) ? $clog2(BLOCK_PIX) : 1;

    // Reject parameter sets that would break frame or block counting.
    if (BLOCK_PIX < 1 || PIX_TOTAL < 1 || PIX_TOTAL > 32767 ||
        (PIX_TOTAL % BLOCK_PIX) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("pix_unpack: illegal PIX_TOTAL/BLOCK_PIX/TIMEOUT_CYC combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [7:0]   hi_q, hi_d;          // first byte of the pair, {R,G}
    logic [7:0]   acc_q, acc_d;        // running XOR of the current block
    logic [14:0]  cnt_q, cnt_d;
    logic [BLK_W-1:0] blk_q, blk_d;    // pixels already in the current block
    logic [11:0]  pix_q, pix_d;
    logic [7:0]   code_q, code_d;
    logic         pix_vld_q, pix_vld_d;
    logic         chk_vld_q, chk_vld_d;
    logic         frame_done_q, frame_done_d;
    logic         recv_q, recv_d;

    logic         in_rx;
    logic [7:0]   acc_nxt;
    logic         blk_last;
    logic         cnt_last;

    assign in_rx    = (bus.i_state == RX_STATE);
    assign acc_nxt  = acc_q ^ bus.i_rx_data;
    assign blk_last = (blk_q == BLK_W'(BLOCK_PIX - 1));
    assign cnt_last = (cnt_q == 15'(PIX_TOTAL - 1));

`ifdef PIX_UNPACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            to_hit;

    // Idle clocks spent waiting for the second byte; any byte or leaving LO restarts it.
    always_comb begin
        to_d   = '0;
        to_hit = 1'b0;
        if (state_q == S_LO && !bus.i_rx_done) begin
            to_d   = to_q + TO_W'(1);
            to_hit = (to_q == TO_W'(TIMEOUT_CYC - 1));
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

    // Next-state and datapath: abort on leaving image-receive mode beats any byte.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        blk_d        = blk_q;
        pix_d        = pix_q;
        code_d       = code_q;
        pix_vld_d    = 1'b0;
        chk_vld_d    = 1'b0;
        frame_done_d = 1'b0;
        recv_d       = recv_q;
        case (state_q)
            S_IDLE: begin
                if (in_rx) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    acc_d   = '0;
                    blk_d   = '0;
                    recv_d  = 1'b1;
                end
            end
            S_HI: begin
                if (!in_rx) begin
                    state_d = S_IDLE;
                    recv_d  = 1'b0;
                end else if (bus.i_rx_done) begin
                    hi_d    = bus.i_rx_data;
                    acc_d   = acc_nxt;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (!in_rx) begin
                    state_d = S_IDLE;
                    recv_d  = 1'b0;
                end else if (bus.i_rx_done) begin
                    pix_d     = {hi_q, bus.i_rx_data[7:4]};
                    pix_vld_d = 1'b1;
                    cnt_d     = cnt_q + 15'd1;
                    state_d   = S_HI;
                    if (blk_last) begin
                        code_d    = acc_nxt;
                        chk_vld_d = 1'b1;
                        acc_d     = '0;
                        blk_d     = '0;
                    end else begin
                        acc_d = acc_nxt;
                        blk_d = blk_q + BLK_W'(1);
                    end
                    if (cnt_last) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                    end
                end
`ifdef PIX_UNPACK_TIMEOUT_EN
                else if (to_hit) begin
                    // Half pixel went stale: take its byte back out of the block XOR.
                    acc_d   = acc_q ^ hi_q;
                    state_d = S_HI;
                end
`endif
            end
            S_DONE: begin
                recv_d = 1'b0;
                if (!in_rx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                recv_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            blk_q        <= '0;
            pix_q        <= '0;
            code_q       <= '0;
            pix_vld_q    <= 1'b0;
            chk_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            recv_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            blk_q        <= blk_d;
            pix_q        <= pix_d;
            code_q       <= code_d;
            pix_vld_q    <= pix_vld_d;
            chk_vld_q    <= chk_vld_d;
            frame_done_q <= frame_done_d;
            recv_q       <= recv_d;
        end
    end

    assign bus.o_pix         = pix_q;
    assign bus.o_pix_valid   = pix_vld_q;
    assign bus.o_pix_cnt     = cnt_q;
    assign bus.o_receiving   = recv_q;
    assign bus.o_check_code  = code_q;
    assign bus.o_check_valid = chk_vld_q;
    assign bus.o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_pix_unpack.sv
// Bench for pix_unpack: table of pixel pairs over one frame, hand sequences for abort,
// timeout and reset, then random bytes/state/reset against a queue-based reference model.
module tb_pix_unpack;
    localparam int PT = 8;
    localparam int BP = 2;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pix_unpack_if bus();

    pix_unpack #(.PIX_TOTAL(PT), .BLOCK_PIX(BP), .TIMEOUT_CYC(TO)) dut (
        .i_clk_sys (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    bit          m_active, m_done, m_recv, m_pv, m_cv, m_fd;
    logic [7:0]  m_first[$];
    logic [7:0]  m_blk[$];
    int          m_cnt, m_idle;
    logic [11:0] m_pix;
    logic [7:0]  m_code;

    function automatic void model_reset();
        m_active = 0; m_done = 0; m_recv = 0; m_pv = 0; m_cv = 0; m_fd = 0;
        m_first.delete(); m_blk.delete();
        m_cnt = 0; m_idle = 0; m_pix = '0; m_code = '0;
    endfunction

    function automatic void model_step(logic [7:0] st, logic dn, logic [7:0] d);
        logic [7:0] first;
        logic [7:0] x;
        m_pv = 0; m_cv = 0; m_fd = 0;
        if (rst) begin
            model_reset();
        end else if (m_done) begin
            m_recv = 0;
            if (st != 8'd2) m_done = 0;
        end else if (!m_active) begin
            if (st == 8'd2) begin
                m_active = 1; m_recv = 1; m_cnt = 0; m_idle = 0;
                m_blk.delete(); m_first.delete();
            end
        end else if (st != 8'd2) begin
            m_active = 0; m_recv = 0; m_first.delete();
        end else if (dn) begin
            m_idle = 0;
            m_blk.push_back(d);
            if (m_first.size() == 0) begin
                m_first.push_back(d);
            end else begin
                first = m_first.pop_front();
                m_pix = {first, d[7:4]};
                m_pv  = 1;
                m_cnt++;
                if (m_cnt % BP == 0) begin
                    x = 8'h00;
                    foreach (m_blk[k]) x ^= m_blk[k];
                    m_code = x; m_cv = 1; m_blk.delete();
                end
                if (m_cnt == PT) begin
                    m_fd = 1; m_active = 0; m_done = 1;
                end
            end
        end
`ifdef PIX_UNPACK_TIMEOUT_EN
        else if (m_first.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                void'(m_blk.pop_back());
                m_first.delete();
                m_idle = 0;
            end
        end
`endif
    endfunction

    function automatic logic [63:0] dut_outs();
        return {25'd0, bus.o_pix, bus.o_pix_valid, bus.o_pix_cnt, bus.o_receiving,
                bus.o_check_code, bus.o_check_valid, bus.o_frame_done};
    endfunction

    function automatic logic [63:0] model_outs();
        return {25'd0, m_pix, m_pv, 15'(m_cnt), m_recv, m_code, m_cv, m_fd};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Apply one clock of inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic [7:0] st, input logic dn, input logic [7:0] d);
        bus.i_state   = st;
        bus.i_rx_done = dn;
        bus.i_rx_data = d;
        model_step(st, dn, d);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] pix;
        int          cnt;
        logic        cv;
        logic [7:0]  code;  // o_check_code after this pixel (held between strobes)
        logic        fd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st_cur;
        tbl[0] = '{8'h12, 8'h30, 12'h123, 1, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{8'h45, 8'h60, 12'h456, 2, 1'b1, 8'h07, 1'b0};
        tbl[2] = '{8'hAB, 8'hCD, 12'hABC, 3, 1'b0, 8'h07, 1'b0};
        tbl[3] = '{8'h01, 8'hF0, 12'h01F, 4, 1'b1, 8'h97, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 12'hFFF, 5, 1'b0, 8'h97, 1'b0};
        tbl[5] = '{8'h00, 8'h0F, 12'h000, 6, 1'b1, 8'h0F, 1'b0};
        tbl[6] = '{8'h5A, 8'hA5, 12'h5AA, 7, 1'b0, 8'h0F, 1'b0};
        tbl[7] = '{8'h3C, 8'hC7, 12'h3CC, 8, 1'b1, 8'h04, 1'b1};

        bus.i_state = '0; bus.i_rx_done = 1'b0; bus.i_rx_data = '0;
        rst = 1'b1;
        model_reset();
        cyc(8'd0, 1'b0, 8'h00);
        cyc(8'd0, 1'b0, 8'h00);
        chk("reset_outs", dut_outs(), 64'd0);
        rst = 1'b0;

        // Bytes outside image-receive mode are ignored.
        cyc(8'd0, 1'b1, 8'h55);
        chk("idle_byte", dut_outs(), 64'd0);

        cyc(8'd2, 1'b0, 8'h00);
        chk("recv_rise", bus.o_receiving, 1);
        chk("cnt_start", bus.o_pix_cnt, 0);

        // One full frame of pixel pairs.
        for (int i = 0; i < 8; i++) begin
            cyc(8'd2, 1'b1, tbl[i].b0);
            chk($sformatf("t%0d_hi_novld", i), bus.o_pix_valid, 0);
            cyc(8'd2, 1'b0, 8'h00);
            cyc(8'd2, 1'b1, tbl[i].b1);
            chk($sformatf("t%0d_pix", i),  bus.o_pix, tbl[i].pix);
            chk($sformatf("t%0d_vld", i),  bus.o_pix_valid, 1);
            chk($sformatf("t%0d_cnt", i),  bus.o_pix_cnt, tbl[i].cnt);
            chk($sformatf("t%0d_cv", i),   bus.o_check_valid, tbl[i].cv);
            chk($sformatf("t%0d_code", i), bus.o_check_code, tbl[i].code);
            chk($sformatf("t%0d_fd", i),   bus.o_frame_done, tbl[i].fd);
            chk($sformatf("t%0d_recv", i), bus.o_receiving, 1);
            cyc(8'd2, 1'b0, 8'h00);
            chk($sformatf("t%0d_gap", i),
                {bus.o_pix_valid, bus.o_check_valid, bus.o_frame_done, bus.o_pix, bus.o_receiving},
                {3'b000, tbl[i].pix, (i != 7)});
        end

        // Bytes after a completed frame produce nothing.
        cyc(8'd2, 1'b1, 8'h99);
        cyc(8'd2, 1'b1, 8'h88);
        chk("done_ignore_vld", bus.o_pix_valid, 0);
        chk("done_ignore_cnt", bus.o_pix_cnt, 8);

        // Leave and re-enter: counter restarts.
        cyc(8'd1, 1'b0, 8'h00);
        cyc(8'd2, 1'b0, 8'h00);
        chk("restart_cnt", bus.o_pix_cnt, 0);
        chk("restart_recv", bus.o_receiving, 1);

        // Mid-frame abort with a latched first byte.
        cyc(8'd2, 1'b1, 8'h12);
        cyc(8'd2, 1'b1, 8'h30);
        chk("abort_pre_cnt", bus.o_pix_cnt, 1);
        cyc(8'd2, 1'b1, 8'hAB);
        cyc(8'd1, 1'b0, 8'h00);
        chk("abort_recv", bus.o_receiving, 0);
        chk("abort_cnt_hold", bus.o_pix_cnt, 1);
        cyc(8'd1, 1'b1, 8'h50);
        chk("abort_no_pix", {bus.o_pix_valid, bus.o_check_valid, bus.o_frame_done}, 0);
        cyc(8'd2, 1'b0, 8'h00);
        chk("reenter_cnt", bus.o_pix_cnt, 0);
        chk("reenter_recv", bus.o_receiving, 1);

        // Byte arriving in the same cycle as the abort is dropped.
        cyc(8'd2, 1'b1, 8'h77);
        cyc(8'd1, 1'b1, 8'h80);
        chk("same_cycle_abort", {bus.o_pix_valid, bus.o_receiving}, 0);
        cyc(8'd2, 1'b0, 8'h00);

        // Stale first byte followed by a fresh pair.
        cyc(8'd2, 1'b1, 8'h12);
        repeat (TO) cyc(8'd2, 1'b0, 8'h00);
        cyc(8'd2, 1'b1, 8'h34);
`ifdef PIX_UNPACK_TIMEOUT_EN
        chk("to_first_novld", bus.o_pix_valid, 0);
        cyc(8'd2, 1'b1, 8'h50);
        chk("to_pix", {bus.o_pix_valid, bus.o_pix}, {1'b1, 12'h345});
`else
        chk("noto_pix", {bus.o_pix_valid, bus.o_pix}, {1'b1, 12'h123});
        cyc(8'd2, 1'b1, 8'h50);
        chk("noto_next_novld", bus.o_pix_valid, 0);
`endif

        // Reset while waiting for the second byte.
        cyc(8'd1, 1'b0, 8'h00);
        cyc(8'd2, 1'b0, 8'h00);
        cyc(8'd2, 1'b1, 8'h12);
        rst = 1'b1;
        cyc(8'd2, 1'b0, 8'h00);
        chk("rst_lo_outs", dut_outs(), 64'd0);
        rst = 1'b0;
        cyc(8'd2, 1'b0, 8'h00);
        chk("rst_lo_recv", bus.o_receiving, 1);
        cyc(8'd2, 1'b1, 8'h77);
        cyc(8'd2, 1'b1, 8'h80);
        chk("rst_lo_pix", {bus.o_pix_valid, bus.o_pix, bus.o_pix_cnt}, {1'b1, 12'h778, 15'd1});

        // Random traffic against the reference model.
        rst = 1'b1;
        cyc(8'd0, 1'b0, 8'h00);
        rst = 1'b0;
        st_cur = 8'd2;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 49) == 0)
                st_cur = (st_cur == 8'd2) ? 8'($urandom_range(0, 3) == 2 ? 3 : $urandom_range(0, 1)) : 8'd2;
            rst = ($urandom_range(0, 999) == 0);
            cyc(st_cur, ($urandom_range(0, 2) == 0), 8'($urandom));
            chk("rand_outs", dut_outs(), model_outs());
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
